// File: rtl/seq_tx_pkg.sv
// Shared types and defaults for the seq_pattern_tx serial sync-pattern transmitter.
// Optional parity bit is enabled by defining SEQ_TX_PARITY_EN.
package seq_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_GAP    = 3'd4
  } state_e;

  localparam int unsigned DEFAULT_SYNC_W = 4;
  localparam logic [DEFAULT_SYNC_W-1:0] DEFAULT_SYNC_PAT = 4'b1101;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_tx_shreg.sv
// Loadable MSB-first shift register: parallel load wins over shift, zeros shift in.
module seq_tx_shreg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         shift_i,
  output logic         msb_o
);

  logic [W-1:0] sr_q;

  // Shift register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= load_val_i;
    end else if (shift_i) begin
      sr_q <= sr_q << 1;
    end
  end

  assign msb_o = sr_q[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: sync pattern, payload MSB first, optional even parity,
// then idle-low gap. Parity bit is enabled by defining SEQ_TX_PARITY_EN.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int unsigned        DATA_W     = 8,
  parameter int unsigned        SYNC_W     = DEFAULT_SYNC_W,
  parameter logic [SYNC_W-1:0]  SYNC_PAT   = SYNC_W'(DEFAULT_SYNC_PAT),
  parameter int unsigned        GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              tx_bit,
  output logic              tx_active,
  output logic              frame_done
);

  localparam int unsigned CNT_W = $clog2(max3(SYNC_W, DATA_W, GAP_CYCLES)) + 1;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t SYNC_LOAD = cnt_t'(SYNC_W - 1);
  localparam cnt_t DATA_LOAD = cnt_t'(DATA_W - 1);
  localparam cnt_t GAP_LOAD  = cnt_t'(GAP_CYCLES - 1);

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  logic   tx_bit_q, tx_bit_d;
  logic   tx_active_q, tx_active_d;
  logic   frame_done_q, frame_done_d;
  logic   accept;
  logic   data_shift, sync_shift;
  logic   data_msb, sync_msb;

  assign data_ready = (state_q == ST_IDLE);
  assign accept     = data_valid & data_ready;
  assign tx_bit     = tx_bit_q;
  assign tx_active  = tx_active_q;
  assign frame_done = frame_done_q;

  // The tx_bit register is loaded with the bit for the upcoming state, so each shift
  // register is advanced the same cycle its MSB is copied out. The sync register is
  // therefore loaded pre-shifted: its first bit goes straight to tx_bit at accept.
  seq_tx_shreg #(.W(DATA_W)) u_data_sr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .load_val_i (data_in),
    .shift_i    (data_shift),
    .msb_o      (data_msb)
  );

  seq_tx_shreg #(.W(SYNC_W)) u_sync_sr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .load_val_i (SYNC_PAT << 1),
    .shift_i    (sync_shift),
    .msb_o      (sync_msb)
  );

`ifdef SEQ_TX_PARITY_EN
  logic parity_q;

  // Even parity of the word captured at accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^data_in;
    end
  end
`endif

  // State, counter and registered line outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      tx_bit_q     <= 1'b0;
      tx_active_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_active_q  <= tx_active_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state logic; outputs are computed for the state being entered.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tx_bit_d     = 1'b0;
    tx_active_d  = 1'b0;
    frame_done_d = 1'b0;
    data_shift   = 1'b0;
    sync_shift   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_SYNC;
          cnt_d       = SYNC_LOAD;
          tx_bit_d    = SYNC_PAT[SYNC_W-1];
          tx_active_d = 1'b1;
        end
      end
      ST_SYNC: begin
        tx_active_d = 1'b1;
        if (cnt_q == '0) begin
          state_d    = ST_DATA;
          cnt_d      = DATA_LOAD;
          tx_bit_d   = data_msb;
          data_shift = 1'b1;
        end else begin
          cnt_d      = cnt_q - cnt_t'(1);
          tx_bit_d   = sync_msb;
          sync_shift = 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
`ifdef SEQ_TX_PARITY_EN
          state_d     = ST_PARITY;
          tx_bit_d    = parity_q;
          tx_active_d = 1'b1;
`else
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
`endif
        end else begin
          cnt_d       = cnt_q - cnt_t'(1);
          tx_bit_d    = data_msb;
          tx_active_d = 1'b1;
          data_shift  = 1'b1;
        end
      end
`ifdef SEQ_TX_PARITY_EN
      ST_PARITY: begin
        state_d = ST_GAP;
        cnt_d   = GAP_LOAD;
      end
`endif
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: directed frames plus randomized traffic,
// checked cycle by cycle against a frame-level expected-output queue.
module tb_seq_pattern_tx;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned SYNC_W     = 4;
  localparam int unsigned GAP_CYCLES = 2;
  localparam logic [3:0]  SYNC_PAT   = 4'b1101;
`ifdef SEQ_TX_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              data_valid = 1'b0;
  logic              data_ready;
  logic              tx_bit;
  logic              tx_active;
  logic              frame_done;

  seq_pattern_tx #(
    .DATA_W     (DATA_W),
    .SYNC_W     (SYNC_W),
    .SYNC_PAT   (SYNC_PAT),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .tx_bit     (tx_bit),
    .tx_active  (tx_active),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic tx;
    logic act;
    logic done;
    logic rdy;
  } exp_t;

  localparam exp_t IDLE_E = '{tx: 1'b0, act: 1'b0, done: 1'b0, rdy: 1'b1};

  exp_t q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   acc;

  task automatic chk(input string tag, input logic got, input logic expv);
    n_cmp++;
    assert (got === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b at t=%0t", tag, got, expv, $time);
    end
  endtask

  task automatic check_all();
    chk("tx_bit", tx_bit, cur.tx);
    chk("tx_active", tx_active, cur.act);
    chk("frame_done", frame_done, cur.done);
    chk("data_ready", data_ready, cur.rdy);
  endtask

  // Expected line content for one whole frame, starting the cycle after accept.
  task automatic push_frame(input logic [DATA_W-1:0] d);
    logic [3:0] sp;
    exp_t       e;
    sp = SYNC_PAT;
    for (int i = SYNC_W - 1; i >= 0; i--) begin
      e = '{tx: sp[i], act: 1'b1, done: 1'b0, rdy: 1'b0};
      q.push_back(e);
    end
    for (int i = DATA_W - 1; i >= 0; i--) begin
      e = '{tx: d[i], act: 1'b1, done: 1'b0, rdy: 1'b0};
      q.push_back(e);
    end
    if (PAR_BITS != 0) begin
      e = '{tx: ^d, act: 1'b1, done: 1'b0, rdy: 1'b0};
      q.push_back(e);
    end
    for (int unsigned i = 0; i < GAP_CYCLES; i++) begin
      e = '{tx: 1'b0, act: 1'b0, done: 1'b0, rdy: 1'b0};
      q.push_back(e);
    end
    e = '{tx: 1'b0, act: 1'b0, done: 1'b1, rdy: 1'b1};
    q.push_back(e);
  endtask

  // One clock: drive inputs, advance the model, check outputs 1 time unit after the edge.
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d, output bit accepted);
    data_valid = v;
    data_in    = d;
    accepted   = v && cur.rdy && rst;
    if (accepted) push_frame(d);
    @(posedge clk);
    #1;
    if (!rst || q.size() == 0) cur = IDLE_E;
    else cur = q.pop_front();
    check_all();
  endtask

  task automatic idle(input int n);
    bit a;
    for (int k = 0; k < n; k++) cycle(1'b0, DATA_W'($urandom), a);
  endtask

  // Hold data_valid high with the word until the model accepts it.
  task automatic send(input logic [DATA_W-1:0] d);
    bit a;
    a = 1'b0;
    for (int k = 0; k < 64 && !a; k++) cycle(1'b1, d, a);
    if (!a) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: word %h never accepted", d);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    q.delete();
    cur = IDLE_E;
    #1;
    check_all();
    idle(n);
    rst = 1'b1;
  endtask

  initial begin
    cur = IDLE_E;
    #1;
    check_all();
    idle(3);
    rst = 1'b1;
    idle(10);

    // Single frames, including parity-1 and parity-0 words.
    send(8'hA5);
    idle(18);
    send(8'h07);
    idle(18);
    send(8'hA5);
    idle(5);

    // Back-to-back with data_valid held high throughout.
    send(8'hFF);
    send(8'h00);
    idle(20);

    // Reset during the fourth data bit, then a clean frame.
    send(8'hA5);
    idle(7);
    do_reset(2);
    idle(2);
    send(8'h3C);
    idle(20);

    // Random traffic with data_in changing every cycle.
    for (int k = 0; k < 600; k++) begin
      cycle(logic'($urandom_range(0, 3) != 0), DATA_W'($urandom), acc);
    end
    do_reset(2);
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
